// File: rtl/realvalue2dacvolt.sv
// Converts a board-current / gap-voltage setpoint pair into two 24-bit SPI frames
// (channel A, then channel B) for a dual DAC. Define DAC_SAT_EN to clamp codes to +/-10000 mV.
module realvalue2dacvolt #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic               ad_clk,
    input  logic               rst_n,
    input  logic signed [15:0] set_current,
    input  logic signed [15:0] set_voltage,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               dac_sclk,
    output logic               dac_cs_n,
    output logic               dac_mosi,
    output logic               busy,
    output logic               done,
    output logic               sat_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_SHIFT_A,
        S_GAP,
        S_SHIFT_B,
        S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
    localparam logic [7:0] CMD_A    = 8'h30;
    localparam logic [7:0] CMD_B    = 8'h31;

    // Returns {clipped, code}; without DAC_SAT_EN the code simply wraps to 16 bits.
    function automatic logic [16:0] to_code(input logic signed [31:0] v);
        logic [16:0] r;
        r = {1'b0, v[15:0]};
`ifdef DAC_SAT_EN
        if (v > 32'sd10000) begin
            r = {1'b1, 16'h2710};
        end else if (v < -32'sd10000) begin
            r = {1'b1, 16'hD8F0};
        end
`endif
        return r;
    endfunction

    state_t             state_q, state_d;
    logic               run_q, run_d;
    logic               calc_q, calc_d;
    logic signed [15:0] cur_q, cur_d;
    logic signed [15:0] volt_q, volt_d;
    logic signed [31:0] prod_a_q, prod_a_d;
    logic signed [31:0] prod_b_q, prod_b_d;
    logic [15:0]        code_b_q, code_b_d;
    logic               sat_flag_q, sat_flag_d;
    logic [23:0]        sr_q, sr_d;
    logic [7:0]         div_q, div_d;
    logic [4:0]         bit_q, bit_d;
    logic               hi_q, hi_d;
    logic               tail_q, tail_d;
    logic [7:0]         gap_q, gap_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;

    logic signed [31:0] cur_ext, volt_ext, calc_a, calc_b;
    logic [16:0]        code_a, code_b;
    logic               in_shift, frame_end, accept;

    assign code_a = to_code(prod_a_q);
    assign code_b = to_code(prod_b_q);

    assign in_ready = run_q && (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign sat_flag = sat_flag_q;
    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    assign dac_mosi = mosi_q;

    always_comb begin
        cur_ext  = {{16{cur_q[15]}}, cur_q};
        volt_ext = {{16{volt_q[15]}}, volt_q};
        calc_a   = 32'sd5000 - (32'sd250 * cur_ext);
        calc_b   = (-(32'sd1000 * volt_ext)) / 32'sd28;
    end

    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        calc_d     = calc_q;
        cur_d      = cur_q;
        volt_d     = volt_q;
        prod_a_d   = prod_a_q;
        prod_b_d   = prod_b_q;
        code_b_d   = code_b_q;
        sat_flag_d = sat_flag_q;
        sr_d       = sr_q;
        div_d      = div_q;
        bit_d      = bit_q;
        hi_d       = hi_q;
        tail_d     = tail_q;
        gap_d      = gap_q;
        frame_end  = 1'b0;

        // Bus outputs lag the serializer state by one cycle, so chip select drops
        // one cycle after a shift state is entered.
        in_shift = (state_q == S_SHIFT_A) || (state_q == S_SHIFT_B);
        cs_n_d   = !in_shift;
        sclk_d   = in_shift && hi_q;
        mosi_d   = in_shift && sr_q[23];

        // Each bit: CLK_DIV cycles low then CLK_DIV high; a CLK_DIV low tail closes the frame.
        if (in_shift) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (tail_q) begin
                    frame_end = 1'b1;
                end else if (!hi_q) begin
                    hi_d = 1'b1;
                end else begin
                    hi_d = 1'b0;
                    sr_d = {sr_q[22:0], 1'b0};
                    if (bit_q == 5'd23) begin
                        tail_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cur_d   = set_current;
                    volt_d  = set_voltage;
                    calc_d  = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (!calc_q) begin
                    prod_a_d = calc_a;
                    prod_b_d = calc_b;
                    calc_d   = 1'b1;
                end else begin
                    code_b_d   = code_b[15:0];
                    sat_flag_d = code_a[16] | code_b[16];
                    sr_d       = {CMD_A, code_a[15:0]};
                    div_d      = '0;
                    bit_d      = '0;
                    hi_d       = 1'b0;
                    tail_d     = 1'b0;
                    state_d    = S_SHIFT_A;
                end
            end
            S_SHIFT_A: begin
                if (frame_end) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    sr_d    = {CMD_B, code_b_q};
                    div_d   = '0;
                    bit_d   = '0;
                    hi_d    = 1'b0;
                    tail_d  = 1'b0;
                    state_d = S_SHIFT_B;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_SHIFT_B: begin
                if (frame_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            run_q      <= 1'b0;
            calc_q     <= 1'b0;
            cur_q      <= '0;
            volt_q     <= '0;
            prod_a_q   <= '0;
            prod_b_q   <= '0;
            code_b_q   <= '0;
            sat_flag_q <= 1'b0;
            sr_q       <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            hi_q       <= 1'b0;
            tail_q     <= 1'b0;
            gap_q      <= '0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            calc_q     <= calc_d;
            cur_q      <= cur_d;
            volt_q     <= volt_d;
            prod_a_q   <= prod_a_d;
            prod_b_q   <= prod_b_d;
            code_b_q   <= code_b_d;
            sat_flag_q <= sat_flag_d;
            sr_q       <= sr_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            hi_q       <= hi_d;
            tail_q     <= tail_d;
            gap_q      <= gap_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

endmodule

// File: tb/tb_realvalue2dacvolt.sv
// Self-checking bench for realvalue2dacvolt: table vectors, random setpoints, held-valid and reset-abort sequences.
module tb_realvalue2dacvolt;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 4;

    logic               ad_clk = 1'b0;
    logic               rst_n  = 1'b0;
    logic signed [15:0] set_current = '0;
    logic signed [15:0] set_voltage = '0;
    logic               in_valid = 1'b0;
    logic               in_ready, dac_sclk, dac_cs_n, dac_mosi, busy, done, sat_flag;

    realvalue2dacvolt #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .ad_clk      (ad_clk),
        .rst_n       (rst_n),
        .set_current (set_current),
        .set_voltage (set_voltage),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dac_sclk    (dac_sclk),
        .dac_cs_n    (dac_cs_n),
        .dac_mosi    (dac_mosi),
        .busy        (busy),
        .done        (done),
        .sat_flag    (sat_flag)
    );

    always #10 ad_clk = ~ad_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic signed [15:0] cur;
        logic signed [15:0] volt;
        logic [15:0]        ea;
        logic [15:0]        eb;
        logic               es;
    } vec_t;

    vec_t vecs[8];

    // Expected frames in transmission order; the monitor pops one per completed frame.
    logic [23:0] exp_q[$];

    function automatic logic [16:0] mcode(input int x);
        logic [16:0] r;
        r = {1'b0, 16'(x)};
`ifdef DAC_SAT_EN
        if (x > 10000) r = {1'b1, 16'h2710};
        else if (x < -10000) r = {1'b1, 16'hD8F0};
`endif
        return r;
    endfunction

    // Frame monitor, sampled on the falling ad_clk edge.
    int          nbits = 0, viol = 0, since_rise = 0, since_fall = 0, high_len = 0;
    logic [23:0] sh = '0;
    logic        p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;

    always @(negedge ad_clk) begin
        if (!rst_n) begin
            nbits = 0; viol = 0; sh = '0; since_rise = 0; since_fall = 0; high_len = 0;
            p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0;
        end else begin
            since_rise++;
            since_fall++;
            if (dac_sclk && !p_sclk) begin
                if (dac_mosi !== p_mosi) viol++;
                if (nbits > 0 && since_rise != 2 * CLK_DIV) viol++;
                since_rise = 0;
                if (!dac_cs_n) begin
                    sh = {sh[22:0], dac_mosi};
                    nbits++;
                end
            end
            if (dac_sclk && p_sclk && dac_mosi !== p_mosi) viol++;
            if (!dac_sclk && p_sclk) since_fall = 0;
            if (!dac_cs_n && p_cs) begin
                if (exp_q.size() > 0 && exp_q[0][23:16] == 8'h31)
                    check("cs_gap_len", high_len, CS_GAP);
            end else if (dac_cs_n) begin
                high_len = p_cs ? high_len + 1 : 1;
            end
            if (dac_cs_n && !p_cs) begin
                check("frame_bits", nbits, 24);
                check("frame_end_sclk_low", dac_sclk, 0);
                check("cs_rise_after_fall", since_fall, CLK_DIV);
                check("mosi_timing", viol, 0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_frame: got %06h with no frame expected", sh);
                end else begin
                    check("frame", sh, exp_q.pop_front());
                end
                nbits = 0;
                viol  = 0;
            end
            p_cs   = dac_cs_n;
            p_sclk = dac_sclk;
            p_mosi = dac_mosi;
        end
    end

    // Call on a falling edge; returns on the falling edge after the transaction ends.
    task automatic send(input logic signed [15:0] c, input logic signed [15:0] v,
                        input logic [15:0] ea, input logic [15:0] eb, input logic es,
                        input string tag);
        int   n, nd;
        logic cs2, cs3, busy_mid;
        n = 0;
        while (!in_ready && n < 400) begin
            @(negedge ad_clk);
            n++;
        end
        if (!in_ready) begin
            check({tag, "_ready_timeout"}, 0, 1);
            return;
        end
        set_current = c;
        set_voltage = v;
        in_valid    = 1'b1;
        exp_q.push_back({8'h30, ea});
        exp_q.push_back({8'h31, eb});
        @(posedge ad_clk);
        #1;
        in_valid    = 1'b0;
        set_current = 16'($urandom);
        set_voltage = 16'($urandom);
        n = 0; nd = 0; cs2 = 1'b0; cs3 = 1'b1; busy_mid = 1'b0;
        while (n < 400) begin
            @(posedge ad_clk);
            #1;
            n++;
            if (n == 2) cs2 = dac_cs_n;
            if (n == 3) cs3 = dac_cs_n;
            if (n == 50) busy_mid = busy;
            if (n == 60) in_valid = 1'b1;
            if (n == 61) in_valid = 1'b0;
            if (done) nd++;
            if (in_ready) break;
        end
        check({tag, "_cs_fall"}, {cs2, cs3}, 2'b10);
        check({tag, "_busy"}, busy_mid, 1);
        check({tag, "_done_pulses"}, nd, 1);
        check({tag, "_sat"}, sat_flag, es);
        n_checks++;
        if (n >= 200 && n <= 204) n_pass++;
        else $display("FAIL %s_latency: got %0d cycles required 200..204", tag, n);
        @(negedge ad_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n, acc, dn, rc, rv;
        logic [16:0] ma, mb;

        vecs[0] = '{16'sd0,    16'sd28,   16'h1388, 16'hFC18, 1'b0};
        vecs[1] = '{16'sd20,   -16'sd56,  16'h0000, 16'h07D0, 1'b0};
        vecs[2] = '{16'sd0,    16'sd100,  16'h1388, 16'hF20D, 1'b0};
`ifdef DAC_SAT_EN
        vecs[3] = '{-16'sd40,  16'sd0,    16'h2710, 16'h0000, 1'b1};
        vecs[4] = '{16'sd100,  -16'sd300, 16'hD8F0, 16'h2710, 1'b1};
        vecs[5] = '{-16'sd200, 16'sd1,    16'h2710, 16'hFFDD, 1'b1};
`else
        vecs[3] = '{-16'sd40,  16'sd0,    16'h3A98, 16'h0000, 1'b0};
        vecs[4] = '{16'sd100,  -16'sd300, 16'hB1E0, 16'h29DA, 1'b0};
        vecs[5] = '{-16'sd200, 16'sd1,    16'hD6D8, 16'hFFDD, 1'b0};
`endif
        vecs[6] = '{16'sd1,    -16'sd1,   16'h128E, 16'h0023, 1'b0};
        vecs[7] = '{16'sd60,   -16'sd280, 16'hD8F0, 16'h2710, 1'b0};

        repeat (2) @(negedge ad_clk);
        check("reset_outputs", {dac_cs_n, dac_sclk, dac_mosi, busy, done, sat_flag, in_ready}, 7'b1000000);
        rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", in_ready, 0);
        @(posedge ad_clk);
        #1;
        check("ready_after_release", in_ready, 1);
        @(negedge ad_clk);

        for (int i = 0; i < 8; i++)
            send(vecs[i].cur, vecs[i].volt, vecs[i].ea, vecs[i].eb, vecs[i].es, $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) begin
            rc = int'($urandom_range(400)) - 200;
            rv = int'($urandom_range(4000)) - 2000;
            ma = mcode(5000 - 250 * rc);
            mb = mcode(-(1000 * rv) / 28);
            send(16'(rc), 16'(rv), ma[15:0], mb[15:0], ma[16] | mb[16], $sformatf("rand%0d", i));
        end

        // in_valid held high: one acceptance per IDLE visit; a mid-transaction change only affects the next one.
        set_current = 16'sd8;
        set_voltage = -16'sd14;
        in_valid    = 1'b1;
        acc = 0;
        dn  = 0;
        for (int k = 0; k < 800 && dn < 2; k++) begin
            if (k > 0) @(negedge ad_clk);
            if (done) dn++;
            if (k == 50) begin
                set_current = -16'sd3;
                set_voltage = 16'sd42;
            end
            if (in_ready && in_valid) begin
                acc++;
                if (acc == 1) begin
                    exp_q.push_back(24'h300BB8);
                    exp_q.push_back(24'h3101F4);
                end else if (acc == 2) begin
                    exp_q.push_back(24'h301676);
                    exp_q.push_back(24'h31FA24);
                    @(posedge ad_clk);
                    #1;
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        repeat (3) @(negedge ad_clk);
        check("held_valid_accepts", acc, 2);
        check("held_valid_dones", dn, 2);
        check("queue_drained_held", exp_q.size(), 0);

        // Reset asserted in the middle of bit 10 of frame A.
        set_current = 16'sd0;
        set_voltage = 16'sd28;
        in_valid    = 1'b1;
        @(posedge ad_clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (nbits < 10 && n < 500) begin
            @(negedge ad_clk);
            n++;
        end
        check("abort_reached_bit10", nbits, 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {dac_cs_n, dac_sclk, dac_mosi, busy, done, sat_flag, in_ready}, 7'b1000000);
        repeat (2) @(negedge ad_clk);
        check("abort_no_frame_after", {dac_cs_n, dac_sclk}, 2'b10);
        rst_n = 1'b1;
        #1;
        check("abort_ready_before_edge", in_ready, 0);
        @(posedge ad_clk);
        #1;
        check("abort_ready_after_edge", in_ready, 1);
        @(negedge ad_clk);
        send(vecs[0].cur, vecs[0].volt, vecs[0].ea, vecs[0].eb, vecs[0].es, "post_reset");
        send(vecs[2].cur, vecs[2].volt, vecs[2].ea, vecs[2].eb, vecs[2].es, "post_reset2");

        repeat (4) @(negedge ad_clk);
        check("queue_drained_final", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
